ram_mbist_ctrl: RTL and testbench

- March C- memory BIST controller placed directly upstream of the 64x8 core RAM. It owns the RAM's Read/Write/ADDR/DIN pins during test and consumes the RAM's DOUT.
- It multiplexes the functional access path to the RAM when not testing.
- It reports pass/fail, first-failure details and a saturating fail count. A wrapper instruction or test register drives it through a start/abort handshake.

---
 rtl/mbist_pkg.sv | 37 +++
 rtl/mbist_addr_gen.sv | 31 +++
 rtl/ram_mbist_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_ram_mbist_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbist_pkg.sv
// Shared types and constants for the March C- BIST controller: FSM states,
// march element table, and RAM pin encodings.
package mbist_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

  typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} elem_e;

  typedef struct packed {
    logic       up;
    logic [1:0] op_cnt;
    logic       op0_rd;
    logic       op0_one;
    logic       op1_rd;
    logic       op1_one;
  } elem_cfg_t;

  // {Read, Write} pin pairs
  localparam logic [1:0] PIN_WR  = 2'b11;
  localparam logic [1:0] PIN_RD  = 2'b00;
  localparam logic [1:0] PIN_NOP = 2'b10;

  localparam int OPS_TOTAL = 640;

  // March C-: up(w0) up(r0,w1) up(r1,w0) dn(r0,w1) dn(r1,w0) up(r0)
  function automatic elem_cfg_t elem_cfg(input elem_e e);
    case (e)
      M0:      elem_cfg = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0};
      M1:      elem_cfg = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1};
      M2:      elem_cfg = '{1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0};
      M3:      elem_cfg = '{1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1};
      M4:      elem_cfg = '{1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0};
      default: elem_cfg = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    endcase
  endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Up/down march address counter with load-to-0/max, step and last-address flag.
module mbist_addr_gen #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              load_max,
  input  logic              step,
  input  logic              up,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load)      addr_d = load_max ? '1 : '0;
    else if (step) addr_d = up ? addr_q + ADDR_W'(1) : addr_q - ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) addr_q <= '0;
    else        addr_q <= addr_d;
  end

  assign addr = addr_q;
  assign last = up ? (&addr_q) : ~(|addr_q);

endmodule

// File: rtl/ram_mbist_ctrl.sv
// March C- BIST controller in front of the core RAM: owns the RAM pins while
// busy, compares read data one cycle later and records first-fail details.
module ram_mbist_ctrl
  import mbist_pkg::*;
#(
  parameter int                ADDR_W     = 6,
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] BG_PATTERN = '0,
  parameter int                FCNT_W     = 8
) (
  input  logic              CoreIN_CLK,
  input  logic              CoreIN_RESET,
  input  logic              bist_start,
  input  logic              bist_abort,
  input  logic              func_read,
  input  logic              func_write,
  input  logic [ADDR_W-1:0] func_addr,
  input  logic [DATA_W-1:0] func_din,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              bist_busy,
  output logic              bist_done,
  output logic              bist_fail,
  output logic [ADDR_W-1:0] bist_fail_addr,
  output logic [DATA_W-1:0] bist_fail_exp,
  output logic [DATA_W-1:0] bist_fail_act,
  output logic [FCNT_W-1:0] bist_fail_cnt
);

  state_e            state_q, state_d;
  elem_e             elem_q, elem_d, elem_nxt;
  logic              op_idx_q, op_idx_d;
  logic              cap_vld_q, cap_vld_d;
  logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
  logic [DATA_W-1:0] cap_exp_q, cap_exp_d, cap_act_q, cap_act_d;
  logic              done_q, done_d, fail_q, fail_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_exp_q, fail_exp_d, fail_act_q, fail_act_d;
  logic [FCNT_W-1:0] fail_cnt_q, fail_cnt_d;

  elem_cfg_t         cfg, nxt_cfg;
  logic              busy, issue, cur_rd, cur_one, last_op, miscmp;
  logic [DATA_W-1:0] cur_data;
  logic              ag_load, ag_load_max, ag_step, ag_last;
  logic [ADDR_W-1:0] ag_addr;

  mbist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk      (CoreIN_CLK),
    .rst_n    (CoreIN_RESET),
    .load     (ag_load),
    .load_max (ag_load_max),
    .step     (ag_step),
    .up       (cfg.up),
    .addr     (ag_addr),
    .last     (ag_last)
  );

  always_comb begin
    cfg      = elem_cfg(elem_q);
    elem_nxt = elem_e'(elem_q + 3'd1);
    nxt_cfg  = elem_cfg(elem_nxt);
    busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    issue    = (state_q == ST_RUN);
    cur_rd   = op_idx_q ? cfg.op1_rd  : cfg.op0_rd;
    cur_one  = op_idx_q ? cfg.op1_one : cfg.op0_one;
    cur_data = cur_one ? ~BG_PATTERN : BG_PATTERN;
    last_op  = ({1'b0, op_idx_q} == (cfg.op_cnt - 2'd1));
    miscmp   = cap_vld_q && (cap_act_q != cap_exp_q);

    {ram_read, ram_write} = {func_read, func_write};
    ram_addr              = func_addr;
    ram_din               = func_din;
    if (busy) begin
      {ram_read, ram_write} = issue ? (cur_rd ? PIN_RD : PIN_WR) : PIN_NOP;
      ram_addr              = ag_addr;
      ram_din               = cur_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    op_idx_d    = op_idx_q;
    ag_load     = 1'b0;
    ag_load_max = 1'b0;
    ag_step     = 1'b0;
    cap_vld_d   = issue && cur_rd && !bist_abort;
    cap_addr_d  = ag_addr;
    cap_exp_d   = cur_data;
    cap_act_d   = ram_dout;
    done_d      = done_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_exp_d  = fail_exp_q;
    fail_act_d  = fail_act_q;
    fail_cnt_d  = fail_cnt_q;

    // An aborted run freezes the fail record as it stood
    if (miscmp && !bist_abort) begin
      fail_d = 1'b1;
      if (!fail_q) begin
        fail_addr_d = cap_addr_q;
        fail_exp_d  = cap_exp_q;
        fail_act_d  = cap_act_q;
      end
      if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + FCNT_W'(1);
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bist_start && !bist_abort) begin
          state_d     = ST_RUN;
          elem_d      = M0;
          op_idx_d    = 1'b0;
          ag_load     = 1'b1;
          done_d      = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_exp_d  = '0;
          fail_act_d  = '0;
          fail_cnt_d  = '0;
        end
      end
      ST_RUN: begin
        if (bist_abort) state_d = ST_IDLE;
        else if (!last_op) op_idx_d = 1'b1;
        else begin
          op_idx_d = 1'b0;
          if (!ag_last) ag_step = 1'b1;
          else if (elem_q == M5) state_d = ST_DRAIN;
          else begin
            elem_d      = elem_nxt;
            ag_load     = 1'b1;
            ag_load_max = !nxt_cfg.up;
          end
        end
      end
      ST_DRAIN: begin
        state_d = bist_abort ? ST_IDLE : ST_DONE;
        done_d  = !bist_abort;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CoreIN_CLK) begin
    if (!CoreIN_RESET) begin
      state_q     <= ST_IDLE;
      elem_q      <= M0;
      op_idx_q    <= 1'b0;
      cap_vld_q   <= 1'b0;
      cap_addr_q  <= '0;
      cap_exp_q   <= '0;
      cap_act_q   <= '0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_act_q  <= '0;
      fail_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      op_idx_q    <= op_idx_d;
      cap_vld_q   <= cap_vld_d;
      cap_addr_q  <= cap_addr_d;
      cap_exp_q   <= cap_exp_d;
      cap_act_q   <= cap_act_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_exp_q  <= fail_exp_d;
      fail_act_q  <= fail_act_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  assign bist_busy      = busy;
  assign bist_done      = done_q;
  assign bist_fail      = fail_q;
  assign bist_fail_addr = fail_addr_q;
  assign bist_fail_exp  = fail_exp_q;
  assign bist_fail_act  = fail_act_q;
  assign bist_fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_ram_mbist_ctrl.sv
// Directed bench for ram_mbist_ctrl: behavioural 64x8 RAM with injectable
// stuck bits, a queue of expected march ops, and status checks.
module tb_ram_mbist_ctrl;

  localparam int AW = 6;
  localparam int DW = 8;
  localparam int FW = 8;
  localparam int NOPS = 640;

  logic          clk = 1'b0;
  logic          CoreIN_RESET, bist_start, bist_abort;
  logic          func_read, func_write;
  logic [AW-1:0] func_addr, ram_addr, bist_fail_addr;
  logic [DW-1:0] func_din, ram_din, ram_dout, bist_fail_exp, bist_fail_act;
  logic          ram_read, ram_write, bist_busy, bist_done, bist_fail;
  logic [FW-1:0] bist_fail_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } op_t;

  op_t exp_q[$];

  always #5 clk = ~clk;

  ram_mbist_ctrl dut (
    .CoreIN_CLK     (clk),
    .CoreIN_RESET   (CoreIN_RESET),
    .bist_start     (bist_start),
    .bist_abort     (bist_abort),
    .func_read      (func_read),
    .func_write     (func_write),
    .func_addr      (func_addr),
    .func_din       (func_din),
    .ram_read       (ram_read),
    .ram_write      (ram_write),
    .ram_addr       (ram_addr),
    .ram_din        (ram_din),
    .ram_dout       (ram_dout),
    .bist_busy      (bist_busy),
    .bist_done      (bist_done),
    .bist_fail      (bist_fail),
    .bist_fail_addr (bist_fail_addr),
    .bist_fail_exp  (bist_fail_exp),
    .bist_fail_act  (bist_fail_act),
    .bist_fail_cnt  (bist_fail_cnt)
  );

  // RAM model: async read, write on Read=1/Write=1
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          stuck_one, stuck_all;
  logic [DW-1:0] or_m, and_m;

  always_comb begin
    or_m  = '0;
    and_m = '1;
    if (stuck_all) begin
      or_m  = 8'h08;
      and_m = 8'hFE;
    end else if (stuck_one && ram_addr == 6'h2A) begin
      or_m = 8'h08;
    end
  end

  assign ram_dout = (mem[ram_addr] | or_m) & and_m;

  always @(posedge clk) if (ram_read && ram_write) mem[ram_addr] <= ram_din;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic busy, input logic done,
                              input logic fail, input logic [AW-1:0] fa,
                              input logic [DW-1:0] fe, input logic [DW-1:0] fac,
                              input logic [FW-1:0] cnt);
    chk({tag, "_busy"}, 32'(bist_busy), 32'(busy));
    chk({tag, "_done"}, 32'(bist_done), 32'(done));
    chk({tag, "_fail"}, 32'(bist_fail), 32'(fail));
    chk({tag, "_faddr"}, 32'(bist_fail_addr), 32'(fa));
    chk({tag, "_fexp"}, 32'(bist_fail_exp), 32'(fe));
    chk({tag, "_fact"}, 32'(bist_fail_act), 32'(fac));
    chk({tag, "_fcnt"}, 32'(bist_fail_cnt), 32'(cnt));
  endtask

  // Op code {is_read, value} for element e, op slot o of March C-
  function automatic logic [1:0] op_code(input int e, input int o);
    case (e)
      0:       op_code = 2'b00;
      1:       op_code = o ? 2'b01 : 2'b10;
      2:       op_code = o ? 2'b00 : 2'b11;
      3:       op_code = o ? 2'b01 : 2'b10;
      4:       op_code = o ? 2'b00 : 2'b11;
      default: op_code = 2'b10;
    endcase
  endfunction

  task automatic push_march();
    op_t         op;
    logic [1:0]  code;
    int          n, a;
    for (int e = 0; e < 6; e++)
      for (int i = 0; i < 64; i++) begin
        a = (e == 3 || e == 4) ? 63 - i : i;
        n = (e == 0 || e == 5) ? 1 : 2;
        for (int o = 0; o < n; o++) begin
          code    = op_code(e, o);
          op.rd   = !code[1];
          op.wr   = !code[1];
          op.addr = AW'(a);
          op.din  = code[1] ? 8'h00 : (code[0] ? 8'hFF : 8'h00);
          exp_q.push_back(op);
        end
      end
  endtask

  task automatic start_run(input string tag);
    exp_q.delete();
    push_march();
    bist_start = 1'b1;
    tick();
    bist_start = 1'b0;
    chk({tag, "_busy_after_start"}, 32'(bist_busy), 32'd1);
  endtask

  // Compare n issued RAM ops against the queue; random func_* must be ignored
  task automatic run_ops(input string tag, input int n, input int pa, input int pb);
    op_t e, o;
    for (int k = 0; k < n; k++) begin
      func_read  = 1'($urandom);
      func_write = 1'($urandom);
      func_addr  = AW'($urandom);
      func_din   = DW'($urandom);
      bist_start = (k == pa) || (k == pb);
      #1;
      e      = exp_q.pop_front();
      o.rd   = ram_read;
      o.wr   = ram_write;
      o.addr = ram_addr;
      o.din  = (e.rd && e.wr) ? ram_din : 8'h00;
      chk($sformatf("%s_op%0d", tag, k), 32'(o), 32'(e));
      tick();
      bist_start = 1'b0;
    end
    func_read  = 1'b1;
    func_write = 1'b0;
  endtask

  task automatic finish_run(input string tag);
    chk({tag, "_drain_busy"}, 32'(bist_busy), 32'd1);
    chk({tag, "_drain_done"}, 32'(bist_done), 32'd0);
    tick();
  endtask

  initial begin
    CoreIN_RESET = 1'b0;
    bist_start   = 1'b0;
    bist_abort   = 1'b0;
    func_read    = 1'b1;
    func_write   = 1'b0;
    func_addr    = '0;
    func_din     = '0;
    stuck_one    = 1'b0;
    stuck_all    = 1'b0;
    repeat (3) tick();
    check_status("reset", 0, 0, 0, 6'h00, 8'h00, 8'h00, 8'd0);
    CoreIN_RESET = 1'b1;
    tick();

    // Fault-free run and read-back of all words
    start_run("t1");
    run_ops("t1", NOPS, -1, -1);
    finish_run("t1");
    check_status("t1_end", 0, 1, 0, 6'h00, 8'h00, 8'h00, 8'd0);
    for (int a = 0; a < 64; a++) begin
      func_read  = 1'b0;
      func_write = 1'b0;
      func_addr  = AW'(a);
      #1;
      chk($sformatf("t1_rdback%0d", a), 32'(ram_dout), 32'h00);
    end
    func_read = 1'b1;

    // Bit 3 stuck-at-1 at 0x2A: fails in M1, M3, M5
    stuck_one = 1'b1;
    start_run("t2");
    run_ops("t2", NOPS, -1, -1);
    finish_run("t2");
    check_status("t2_end", 0, 1, 1, 6'h2A, 8'h00, 8'h08, 8'd3);
    stuck_one = 1'b0;

    // Every read fails (bit3 stuck-1, bit0 stuck-0): count saturates
    stuck_all = 1'b1;
    start_run("t2s");
    run_ops("t2s", NOPS, -1, -1);
    finish_run("t2s");
    check_status("t2s_end", 0, 1, 1, 6'h00, 8'h00, 8'h08, 8'hFF);

    // Abort at cycle 100; 18 M1 reads have been compared by then
    start_run("t3");
    run_ops("t3", 100, -1, -1);
    bist_abort = 1'b1;
    tick();
    bist_abort = 1'b0;
    check_status("t3_abort", 0, 0, 1, 6'h00, 8'h00, 8'h08, 8'd18);
    func_read  = 1'b1;
    func_write = 1'b0;
    func_addr  = 6'h15;
    func_din   = 8'h33;
    #1;
    chk("t3_func_pins", 32'({ram_read, ram_write}), 32'b10);
    chk("t3_func_addr", 32'(ram_addr), 32'h15);
    chk("t3_func_din", 32'(ram_din), 32'h33);
    bist_start = 1'b1;
    bist_abort = 1'b1;
    tick();
    bist_start = 1'b0;
    bist_abort = 1'b0;
    chk("t3_start_abort_busy", 32'(bist_busy), 32'd0);
    stuck_all = 1'b0;

    // Start pulses during the run are ignored
    start_run("t4");
    run_ops("t4", NOPS, 10, 639);
    finish_run("t4");
    check_status("t4_end", 0, 1, 0, 6'h00, 8'h00, 8'h00, 8'd0);

    // Reset mid-run, then a clean run
    start_run("t5");
    run_ops("t5", 300, -1, -1);
    stuck_one    = 1'b1;
    CoreIN_RESET = 1'b0;
    func_addr    = 6'h09;
    func_din     = 8'hC3;
    tick();
    check_status("t5_reset", 0, 0, 0, 6'h00, 8'h00, 8'h00, 8'd0);
    chk("t5_func_addr", 32'(ram_addr), 32'h09);
    chk("t5_func_din", 32'(ram_din), 32'hC3);
    CoreIN_RESET = 1'b1;
    stuck_one    = 1'b0;
    tick();
    start_run("t5b");
    run_ops("t5b", NOPS, -1, -1);
    finish_run("t5b");
    check_status("t5b_end", 0, 1, 0, 6'h00, 8'h00, 8'h00, 8'd0);

    // Idle functional write/read through the mux
    func_read  = 1'b1;
    func_write = 1'b1;
    func_addr  = 6'h07;
    func_din   = 8'h5A;
    tick();
    func_read  = 1'b0;
    func_write = 1'b0;
    #1;
    chk("t6_rd_data", 32'(ram_dout), 32'h5A);
    check_status("t6_status", 0, 1, 0, 6'h00, 8'h00, 8'h00, 8'd0);
    func_read = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
